// File: rtl/time_of_day_phase_tracker.sv
// -----------------------------------------------------------------------------
// time_of_day_phase_tracker
//
// Purpose:
//   Keeps an hour:minute time of day that advances on a one-minute strobe.
//   Classifies the current hour as day or night against a programmable
//   window [dayStart, dayEnd). The window may wrap midnight.
//   Reports a registered day flag and one-cycle transition pulses.
//   Raises a sticky error flag when a time load or window write carries
//   an out-of-range value.
//
// Ports:
//   clk         in   rising-edge clock for all state
//   rst_n       in   asynchronous active-low reset
//   minTick     in   advance time by one minute (counted every cycle high)
//   load        in   load loadHour:loadMinute (has priority over minTick)
//   loadHour    in   [HW-1:0] hour value for load
//   loadMinute  in   [MW-1:0] minute value for load
//   cfgWr       in   write a new day window
//   cfgStart    in   [HW-1:0] first day hour (inclusive)
//   cfgEnd      in   [HW-1:0] last day hour (exclusive)
//   hourOut     out  [HW-1:0] current hour
//   minuteOut   out  [MW-1:0] current minute
//   isDay       out  1 = current hour is inside the day window
//   dayBegin    out  one-cycle pulse in the first cycle isDay reads 1
//   nightBegin  out  one-cycle pulse in the first cycle isDay reads 0
//   cfgErr      out  sticky out-of-range flag, cleared only by reset
// -----------------------------------------------------------------------------
module time_of_day_phase_tracker #(
    parameter int HOURS_PER_DAY    = 24,
    parameter int MINUTES_PER_HOUR = 60,
    parameter int DAY_START_RST    = 6,
    parameter int DAY_END_RST      = 20,
    localparam int HW = (HOURS_PER_DAY    > 2) ? $clog2(HOURS_PER_DAY)    : 1,
    localparam int MW = (MINUTES_PER_HOUR > 2) ? $clog2(MINUTES_PER_HOUR) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          minTick,
    input  logic          load,
    input  logic [HW-1:0] loadHour,
    input  logic [MW-1:0] loadMinute,
    input  logic          cfgWr,
    input  logic [HW-1:0] cfgStart,
    input  logic [HW-1:0] cfgEnd,
    output logic [HW-1:0] hourOut,
    output logic [MW-1:0] minuteOut,
    output logic          isDay,
    output logic          dayBegin,
    output logic          nightBegin,
    output logic          cfgErr
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // -------------------------------------------------------------------------
    if ((HOURS_PER_DAY < 2) || (HOURS_PER_DAY > 32)) begin : g_bad_hours
        $error("HOURS_PER_DAY must be in 2..32");
    end
    if ((MINUTES_PER_HOUR < 2) || (MINUTES_PER_HOUR > 64)) begin : g_bad_minutes
        $error("MINUTES_PER_HOUR must be in 2..64");
    end
    if ((DAY_START_RST < 0) || (DAY_START_RST >= HOURS_PER_DAY)) begin : g_bad_start
        $error("DAY_START_RST must be in 0..HOURS_PER_DAY-1");
    end
    if ((DAY_END_RST < 0) || (DAY_END_RST >= HOURS_PER_DAY)) begin : g_bad_end
        $error("DAY_END_RST must be in 0..HOURS_PER_DAY-1");
    end

    // Limits held one bit wider than the fields so that HOURS_PER_DAY = 2**HW
    // (or MINUTES_PER_HOUR = 2**MW) still compares correctly.
    localparam logic [HW:0]   C_HOURS     = (HW+1)'(HOURS_PER_DAY);
    localparam logic [MW:0]   C_MINUTES   = (MW+1)'(MINUTES_PER_HOUR);
    localparam logic [HW-1:0] C_HOUR_LAST = HW'(HOURS_PER_DAY - 1);
    localparam logic [MW-1:0] C_MIN_LAST  = MW'(MINUTES_PER_HOUR - 1);
    localparam logic [HW-1:0] C_START_RST = HW'(DAY_START_RST);
    localparam logic [HW-1:0] C_END_RST   = HW'(DAY_END_RST);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Day/night decode of an hour against a window [start, end).
    function automatic logic f_is_day(input logic [HW-1:0] hour,
                                      input logic [HW-1:0] start,
                                      input logic [HW-1:0] stop);
        logic day;
        if (start < stop) begin
            day = (hour >= start) && (hour < stop);
        end else if (start > stop) begin
            // The window wraps through midnight.
            day = (hour >= start) || (hour < stop);
        end else begin
            // An empty window means permanent night.
            day = 1'b0;
        end
        return day;
    endfunction

    // Hour value legal for this day length.
    function automatic logic f_hour_ok(input logic [HW-1:0] hour);
        return ({1'b0, hour} < C_HOURS);
    endfunction

    // Minute value legal for this hour length.
    function automatic logic f_min_ok(input logic [MW-1:0] minute);
        return ({1'b0, minute} < C_MINUTES);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [HW-1:0] r_hour;
    logic [MW-1:0] r_min;
    logic [HW-1:0] r_start;
    logic [HW-1:0] r_end;
    logic          r_is_day;
    logic          r_day_begin;
    logic          r_night_begin;
    logic          r_cfg_err;

    logic          w_load_ok;
    logic          w_cfg_ok;
    logic [HW-1:0] w_hour_nxt;
    logic [MW-1:0] w_min_nxt;
    logic [HW-1:0] w_start_nxt;
    logic [HW-1:0] w_end_nxt;
    logic          w_day_nxt;
    logic          w_err_set;

    // Validity of the load and window-write payloads.
    always_comb begin
        w_load_ok = f_hour_ok(loadHour) && f_min_ok(loadMinute);
        w_cfg_ok  = f_hour_ok(cfgStart) && f_hour_ok(cfgEnd);
    end

    // Next time: a valid load wins and drops a coincident tick. An invalid
    // load is treated as absent, so a coincident tick still counts.
    always_comb begin
        w_hour_nxt = r_hour;
        w_min_nxt  = r_min;
        if (load && w_load_ok) begin
            w_hour_nxt = loadHour;
            w_min_nxt  = loadMinute;
        end else if (minTick) begin
            if (r_min == C_MIN_LAST) begin
                w_min_nxt = '0;
                if (r_hour == C_HOUR_LAST) begin
                    w_hour_nxt = '0;
                end else begin
                    w_hour_nxt = r_hour + HW'(1);
                end
            end else begin
                w_min_nxt = r_min + MW'(1);
            end
        end else begin
            w_hour_nxt = r_hour;
            w_min_nxt  = r_min;
        end
    end

    // Next window, error capture and day decode of the next state, so that
    // isDay lands on the same edge as the hour/window that causes it.
    always_comb begin
        w_start_nxt = r_start;
        w_end_nxt   = r_end;
        if (cfgWr && w_cfg_ok) begin
            w_start_nxt = cfgStart;
            w_end_nxt   = cfgEnd;
        end else begin
            w_start_nxt = r_start;
            w_end_nxt   = r_end;
        end
        w_err_set = (load && !w_load_ok) || (cfgWr && !w_cfg_ok);
        w_day_nxt = f_is_day(w_hour_nxt, w_start_nxt, w_end_nxt);
    end

    // Time, window and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hour    <= '0;
            r_min     <= '0;
            r_start   <= C_START_RST;
            r_end     <= C_END_RST;
            r_cfg_err <= 1'b0;
        end else begin
            r_hour    <= w_hour_nxt;
            r_min     <= w_min_nxt;
            r_start   <= w_start_nxt;
            r_end     <= w_end_nxt;
            r_cfg_err <= r_cfg_err | w_err_set;
        end
    end

    // Day flag and transition pulses. The reset flag equals the decode of the
    // reset state, so the first edge after release cannot produce a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_day      <= f_is_day('0, C_START_RST, C_END_RST);
            r_day_begin   <= 1'b0;
            r_night_begin <= 1'b0;
        end else begin
            r_is_day      <= w_day_nxt;
            r_day_begin   <= w_day_nxt  & ~r_is_day;
            r_night_begin <= ~w_day_nxt &  r_is_day;
        end
    end

    assign hourOut    = r_hour;
    assign minuteOut  = r_min;
    assign isDay      = r_is_day;
    assign dayBegin   = r_day_begin;
    assign nightBegin = r_night_begin;
    assign cfgErr     = r_cfg_err;

endmodule

// File: tb/tb_time_of_day_phase_tracker.sv
// Directed, table-driven bench for time_of_day_phase_tracker (default params).
module tb_time_of_day_phase_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       minTick = 1'b0;
    logic       load = 1'b0;
    logic [4:0] loadHour = 5'd0;
    logic [5:0] loadMinute = 6'd0;
    logic       cfgWr = 1'b0;
    logic [4:0] cfgStart = 5'd0;
    logic [4:0] cfgEnd = 5'd0;
    logic [4:0] hourOut;
    logic [5:0] minuteOut;
    logic       isDay;
    logic       dayBegin;
    logic       nightBegin;
    logic       cfgErr;

    int errors = 0;
    int checks = 0;

    time_of_day_phase_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .minTick    (minTick),
        .load       (load),
        .loadHour   (loadHour),
        .loadMinute (loadMinute),
        .cfgWr      (cfgWr),
        .cfgStart   (cfgStart),
        .cfgEnd     (cfgEnd),
        .hourOut    (hourOut),
        .minuteOut  (minuteOut),
        .isDay      (isDay),
        .dayBegin   (dayBegin),
        .nightBegin (nightBegin),
        .cfgErr     (cfgErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [4:0] lh;
        logic [5:0] lm;
        logic       tk;
        logic       cw;
        logic [4:0] cs;
        logic [4:0] ce;
        logic [4:0] eh;
        logic [5:0] em;
        logic       ed;
        logic       edb;
        logic       enb;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input int lh, input int lm,
                                input logic tk, input logic cw, input int cs,
                                input int ce, input int eh, input int em,
                                input logic ed, input logic edb,
                                input logic enb, input logic eerr);
        vec_t v;
        v.ld = ld; v.lh = 5'(lh); v.lm = 6'(lm); v.tk = tk;
        v.cw = cw; v.cs = 5'(cs); v.ce = 5'(ce);
        v.eh = 5'(eh); v.em = 6'(em);
        v.ed = ed; v.edb = edb; v.enb = enb; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eh, input int em,
                           input int ed, input int edb, input int enb,
                           input int eerr);
        chk({tag, " hour"},  int'(hourOut),    eh);
        chk({tag, " min"},   int'(minuteOut),  em);
        chk({tag, " isDay"}, int'(isDay),      ed);
        chk({tag, " dayB"},  int'(dayBegin),   edb);
        chk({tag, " nghtB"}, int'(nightBegin), enb);
        chk({tag, " err"},   int'(cfgErr),     eerr);
    endtask

    // Advance one edge and sample 1 time unit later; inputs return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        minTick = 1'b0;
        load    = 1'b0;
        cfgWr   = 1'b0;
    endtask

    initial begin
        // ld  lh  lm tk cw cs ce   eh  em  day db nb err
        vecs.push_back(mk(1, 19, 59, 0, 0,  0,  0, 19, 59, 1, 0, 0, 0)); // 0 load 19:59
        vecs.push_back(mk(0,  0,  0, 1, 0,  0,  0, 20,  0, 0, 0, 1, 0)); // 1 tick -> 20:00
        vecs.push_back(mk(0,  0,  0, 0, 0,  0,  0, 20,  0, 0, 0, 0, 0)); // 2 pulse gone
        vecs.push_back(mk(0,  0,  0, 0, 1, 22,  5, 20,  0, 0, 0, 0, 0)); // 3 wrap window
        vecs.push_back(mk(1, 23, 30, 0, 0,  0,  0, 23, 30, 1, 1, 0, 0)); // 4
        vecs.push_back(mk(1,  5,  0, 0, 0,  0,  0,  5,  0, 0, 0, 1, 0)); // 5 end exclusive
        vecs.push_back(mk(1,  4, 59, 0, 0,  0,  0,  4, 59, 1, 1, 0, 0)); // 6
        vecs.push_back(mk(0,  0,  0, 0, 1,  6, 20,  4, 59, 0, 0, 1, 0)); // 7 restore window
        vecs.push_back(mk(1, 23, 59, 0, 0,  0,  0, 23, 59, 0, 0, 0, 0)); // 8
        vecs.push_back(mk(0,  0,  0, 1, 0,  0,  0,  0,  0, 0, 0, 0, 0)); // 9 midnight wrap
        vecs.push_back(mk(1, 24,  0, 0, 0,  0,  0,  0,  0, 0, 0, 0, 1)); // 10 bad load
        vecs.push_back(mk(0,  0,  0, 0, 1, 30,  5,  0,  0, 0, 0, 0, 1)); // 11 bad cfg
        vecs.push_back(mk(1,  6,  0, 0, 0,  0,  0,  6,  0, 1, 1, 0, 1)); // 12 window kept
        vecs.push_back(mk(1, 10,  0, 1, 0,  0,  0, 10,  0, 1, 0, 0, 1)); // 13 load+tick
        vecs.push_back(mk(1, 12,  0, 0, 0,  0,  0, 12,  0, 1, 0, 0, 1)); // 14
        vecs.push_back(mk(0,  0,  0, 0, 1,  8,  8, 12,  0, 0, 0, 1, 1)); // 15 empty window
        vecs.push_back(mk(0,  0,  0, 1, 0,  0,  0, 12,  1, 0, 0, 0, 1)); // 16 held tick 1
        vecs.push_back(mk(0,  0,  0, 1, 0,  0,  0, 12,  2, 0, 0, 0, 1)); // 17 held tick 2
        vecs.push_back(mk(0,  0,  0, 1, 0,  0,  0, 12,  3, 0, 0, 0, 1)); // 18 held tick 3
        vecs.push_back(mk(1, 13,  0, 0, 1, 10, 14, 13,  0, 1, 1, 0, 1)); // 19 cfg+load
        vecs.push_back(mk(1, 13, 59, 0, 0,  0,  0, 13, 59, 1, 0, 0, 1)); // 20
        vecs.push_back(mk(0,  0,  0, 1, 0,  0,  0, 14,  0, 0, 0, 1, 1)); // 21 hit end hour

        // Reset state.
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("post-release", 0, 0, 0, 0, 0, 0);

        // 360 ticks from midnight: night through 05:59, day begins at 06:00.
        for (int i = 0; i < 359; i++) begin
            minTick = 1'b1;
            step();
        end
        chk_all("05:59", 5, 59, 0, 0, 0, 0);
        minTick = 1'b1;
        step();
        chk_all("06:00", 6, 0, 1, 1, 0, 0);
        step();
        chk_all("06:00 hold", 6, 0, 1, 0, 0, 0);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            load       = vecs[i].ld;
            loadHour   = vecs[i].lh;
            loadMinute = vecs[i].lm;
            minTick    = vecs[i].tk;
            cfgWr      = vecs[i].cw;
            cfgStart   = vecs[i].cs;
            cfgEnd     = vecs[i].ce;
            step();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].eh), int'(vecs[i].em),
                    int'(vecs[i].ed), int'(vecs[i].edb), int'(vecs[i].enb),
                    int'(vecs[i].eerr));
        end

        // Reset mid-stream with a load pending: outputs return at once.
        @(negedge clk);
        load       = 1'b1;
        loadHour   = 5'd15;
        loadMinute = 6'd0;
        cfgWr      = 1'b1;
        cfgStart   = 5'd0;
        cfgEnd     = 5'd1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("in rst", 0, 0, 0, 0, 0, 0);
        load  = 1'b0;
        cfgWr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("re-release", 0, 0, 0, 0, 0, 0);
        // Reset window must be back to 6..20.
        load     = 1'b1;
        loadHour = 5'd20;
        step();
        chk_all("rst window end", 20, 0, 0, 0, 0, 0);
        load     = 1'b1;
        loadHour = 5'd19;
        step();
        chk_all("rst window in", 19, 0, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_of_day_phase_tracker.md
TIME_OF_DAY_PHASE_TRACKER -- requirements
Module: time_of_day_phase_tracker

Interface
REQ-001 Parameter HOURS_PER_DAY, default 24, hours per day (range 2..32).
REQ-002 Parameter MINUTES_PER_HOUR, default 60, minutes per hour (range 2..64).
REQ-003 Parameter DAY_START_RST, default 6, reset value of the day-start hour.
REQ-004 Parameter DAY_END_RST, default 20, reset value of the day-end hour (exclusive).
REQ-005 Derived widths: HW = clog2(HOURS_PER_DAY) and MW = clog2(MINUTES_PER_HOUR), each minimum 1.
REQ-006 clk, input, 1, single rising-edge clock for all state.
REQ-007 rst_n, input, 1, asynchronous active-low reset.
REQ-008 minTick, input, 1, one-cycle strobe; advances time by one minute.
REQ-009 load, input, 1, synchronous time load strobe.
REQ-010 loadHour / loadMinute, input, HW / MW, time value applied on load.
REQ-011 cfgWr, input, 1, strobe that writes the day window.
REQ-012 cfgStart / cfgEnd, input, HW / HW, new day-start and day-end hours.
REQ-013 hourOut / minuteOut, output, HW / MW, current registered time.
REQ-014 isDay, output, 1, registered flag: 1 = day, 0 = night.
REQ-015 dayBegin / nightBegin, output, 1, one-cycle pulses on a 0->1 or 1->0 change of isDay.
REQ-016 cfgErr, output, 1, sticky flag set when a write or load is out of range.

Function
REQ-017 Minute counter: on minTick, increments; at MINUTES_PER_HOUR-1 it wraps to 0 and the hour increments.
REQ-018 Hour counter: at HOURS_PER_DAY-1 with minute wrap, wraps to 0.
REQ-019 load has priority over minTick in the same cycle; the loaded time appears on the next edge and that tick is dropped.
REQ-020 load with loadHour >= HOURS_PER_DAY or loadMinute >= MINUTES_PER_HOUR: ignored entirely; sets cfgErr.
REQ-021 cfgWr with either value >= HOURS_PER_DAY: ignored; sets cfgErr. Otherwise dayStart/dayEnd update on the next edge.
REQ-022 cfgWr and load in the same cycle: both take effect.
REQ-023 Day decode uses the next-state hour and the next-state window.
- start < end: day = start <= h < end.
- start > end (window wraps midnight): day = h >= start OR h < end.
- start == end: day = 0 always.
REQ-024 isDay is registered and reflects the current hourOut and window in the same cycle, i.e. one edge after the causing event, with zero extra latency relative to hourOut.
REQ-025 dayBegin is asserted for exactly the one cycle in which isDay first reads 1 after reading 0; nightBegin is the converse. The two pulses are never asserted together.
REQ-026 Changes in isDay caused by load or cfgWr also produce pulses.
REQ-027 minTick pulses held high for N cycles count as N minutes.
REQ-028 cfgErr clears only on reset.

Reset
REQ-029 Assertion of rst_n low asynchronously forces:
- hourOut = 0, minuteOut = 0;
- dayStart = DAY_START_RST, dayEnd = DAY_END_RST;
- isDay = decode of hour 0 with the reset window;
- dayBegin = nightBegin = 0, cfgErr = 0.
REQ-030 No pulse is generated on the first edge after reset release.
REQ-031 Reset asserted mid-operation discards any in-flight load, cfgWr or tick.
REQ-032 Out-of-range parameter values are a compile-time error (elaboration assertion).

Verification
REQ-033 Reset with defaults, then 360 minTicks: at 05:59 isDay = 0; on the edge to 06:00, isDay = 1 and dayBegin pulses for one cycle.
REQ-034 load 19:59, then one minTick: time reads 20:00, isDay 1 -> 0, nightBegin pulses once.
REQ-035 cfgWr start = 22, end = 5, then load 23:30: isDay = 1. Then load 05:00: isDay = 0. Then load 04:59: isDay = 1.
REQ-036 load 23:59, then minTick: time reads 00:00, isDay = 0, no pulse.
REQ-037 Invalid input: load 24:00, or cfgWr start = 30. Time and window are unchanged and cfgErr = 1 until reset.
REQ-038 Simultaneous events:
- load 10:00 with minTick in the same cycle gives exactly 10:00.
- cfgWr start = end = 8 at 12:00 gives isDay 1 -> 0 with a nightBegin pulse.
- rst_n asserted mid-stream returns all outputs to their reset values immediately.
